// File: rtl/cp0_multi.sv
// Parametrised MEM-stage coprocessor 0: SR/Cause/EPC/PRId, NUM_HWINT hardware + 2 software interrupts.
// Optional Count/Compare timer on the top hardware line is built when CP0_TIMER_EN is defined.
module cp0_multi #(
    parameter int unsigned NUM_HWINT = 6,
    parameter logic [31:0] PRID      = 32'h0000_4C51,
    parameter logic [31:0] EPC_RST   = 32'h0000_3000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_HWINT-1:0] hwint,
    input  logic                 exc_valid,
    input  logic [4:0]           exc_code,
    input  logic [31:0]          pc_m,
    input  logic                 bd_m,
    input  logic [4:0]           cp0_addr,
    input  logic [31:0]          cp0_wd,
    input  logic                 cp0_we,
    input  logic                 eret,
    output logic [31:0]          cp0_rd,
    output logic [31:0]          epc,
    output logic                 int_req,
    output logic                 exl
);
    localparam int unsigned HW_LO       = 10;
    localparam logic [4:0]  REG_COUNT   = 5'd9;
    localparam logic [4:0]  REG_COMPARE = 5'd11;
    localparam logic [4:0]  REG_SR      = 5'd12;
    localparam logic [4:0]  REG_CAUSE   = 5'd13;
    localparam logic [4:0]  REG_EPC     = 5'd14;
    localparam logic [4:0]  REG_PRID    = 5'd15;

    logic [NUM_HWINT-1:0] im_q, im_d, hwip_q, hwip_d, tint;
    logic [1:0]           swm_q, swm_d, swip_q, swip_d;
    logic                 ie_q, ie_d, exl_q, exl_d, bd_q, bd_d;
    logic [4:0]           exc_q, exc_d;
    logic [31:0]          epc_q, epc_d;
    logic                 irq, wr_ok;
    logic [31:0]          sr_v, cause_v;
    logic                 unused_bits;

`ifdef CP0_TIMER_EN
    logic [31:0] count_q, count_d, compare_q, compare_d;
    logic        tpend_q, tpend_d;

    always_comb begin
        count_d   = count_q + 32'd1;
        compare_d = compare_q;
        tpend_d   = tpend_q | ((count_q == compare_q) && (compare_q != '0));
        if (wr_ok && cp0_addr == REG_COUNT) count_d = cp0_wd;
        if (wr_ok && cp0_addr == REG_COMPARE) begin
            compare_d = cp0_wd;
            tpend_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q   <= '0;
            compare_q <= '0;
            tpend_q   <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            tpend_q   <= tpend_d;
        end
    end
`endif

    always_comb begin
        tint = '0;
`ifdef CP0_TIMER_EN
        tint[NUM_HWINT-1] = tpend_q;
`endif
    end

    assign irq     = ie_q & ~exl_q & (|({hwip_q, swip_q} & {im_q, swm_q}));
    assign int_req = reset & (irq | (exc_valid & ~exl_q));
    assign wr_ok   = cp0_we & ~int_req;

    always_comb begin
        im_d   = im_q;
        swm_d  = swm_q;
        ie_d   = ie_q;
        exl_d  = exl_q;
        bd_d   = bd_q;
        swip_d = swip_q;
        exc_d  = exc_q;
        epc_d  = epc_q;
        hwip_d = hwint | tint;
        if (int_req) begin
            exl_d = 1'b1;
            bd_d  = bd_m;
            exc_d = irq ? 5'd0 : exc_code;
            epc_d = bd_m ? {pc_m[31:2] - 30'd1, 2'b00} : {pc_m[31:2], 2'b00};
        end else begin
            if (wr_ok && cp0_addr == REG_SR) begin
                im_d  = cp0_wd[HW_LO +: NUM_HWINT];
                swm_d = cp0_wd[9:8];
                exl_d = cp0_wd[1];
                ie_d  = cp0_wd[0];
            end
            if (wr_ok && cp0_addr == REG_CAUSE) swip_d = cp0_wd[9:8];
            if (wr_ok && cp0_addr == REG_EPC) epc_d = {cp0_wd[31:2], 2'b00};
            // eret after a same-cycle SR write: the written value lands, EXL still ends up clear.
            if (eret) exl_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            im_q   <= '0;
            swm_q  <= '0;
            ie_q   <= 1'b0;
            exl_q  <= 1'b0;
            bd_q   <= 1'b0;
            hwip_q <= '0;
            swip_q <= '0;
            exc_q  <= '0;
            epc_q  <= EPC_RST;
        end else begin
            im_q   <= im_d;
            swm_q  <= swm_d;
            ie_q   <= ie_d;
            exl_q  <= exl_d;
            bd_q   <= bd_d;
            hwip_q <= hwip_d;
            swip_q <= swip_d;
            exc_q  <= exc_d;
            epc_q  <= epc_d;
        end
    end

    always_comb begin
        sr_v                       = '0;
        sr_v[HW_LO +: NUM_HWINT]   = im_q;
        sr_v[9:8]                  = swm_q;
        sr_v[1]                    = exl_q;
        sr_v[0]                    = ie_q;
        cause_v                    = '0;
        cause_v[31]                = bd_q;
        cause_v[HW_LO +: NUM_HWINT] = hwip_q;
        cause_v[9:8]               = swip_q;
        cause_v[6:2]               = exc_q;
        case (cp0_addr)
            REG_SR:      cp0_rd = sr_v;
            REG_CAUSE:   cp0_rd = cause_v;
            REG_EPC:     cp0_rd = epc_q;
            REG_PRID:    cp0_rd = PRID;
`ifdef CP0_TIMER_EN
            REG_COUNT:   cp0_rd = count_q;
            REG_COMPARE: cp0_rd = compare_q;
`endif
            default:     cp0_rd = '0;
        endcase
    end

    assign epc         = epc_q;
    assign exl         = exl_q;
    assign unused_bits = ^{pc_m[1:0], cp0_wd};
endmodule

// File: tb/tb_cp0_multi.sv
// Bench for cp0_multi: word-level reference model compared every cycle, plus directed literal checks.
module tb_cp0_multi;
    localparam int unsigned N       = 6;
    localparam logic [31:0] PRID    = 32'h0000_4C51;
    localparam logic [31:0] EPC_RST = 32'h0000_3000;
    localparam logic [31:0] HWM     = ((32'd1 << N) - 32'd1) << 10;
    localparam logic [31:0] SRM     = HWM | 32'h0000_0303;
    localparam logic [31:0] TOPBIT  = 32'd1 << (10 + N - 1);

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [N-1:0]  hwint = '0;
    logic          exc_valid = 1'b0;
    logic [4:0]    exc_code = '0;
    logic [31:0]   pc_m = '0;
    logic          bd_m = 1'b0;
    logic [4:0]    cp0_addr = '0;
    logic [31:0]   cp0_wd = '0;
    logic          cp0_we = 1'b0;
    logic          eret = 1'b0;
    logic [31:0]   cp0_rd, epc;
    logic          int_req, exl;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    cp0_multi #(.NUM_HWINT(N), .PRID(PRID), .EPC_RST(EPC_RST)) dut (
        .clk(clk), .reset(reset), .hwint(hwint), .exc_valid(exc_valid), .exc_code(exc_code),
        .pc_m(pc_m), .bd_m(bd_m), .cp0_addr(cp0_addr), .cp0_wd(cp0_wd), .cp0_we(cp0_we),
        .eret(eret), .cp0_rd(cp0_rd), .epc(epc), .int_req(int_req), .exl(exl)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference state kept as whole architectural words.
    logic [31:0] m_sr, m_cause, m_ip, m_epc, m_count, m_compare;
    logic        m_tpend;
    bit          ready = 0;

    function automatic logic m_irq();
        return m_sr[0] & ~m_sr[1] & (|((m_ip | (m_cause & 32'h300)) & m_sr & (HWM | 32'h300)));
    endfunction

    function automatic logic m_intreq();
        return reset & (m_irq() | (exc_valid & ~m_sr[1]));
    endfunction

    function automatic logic [31:0] m_rd(input logic [4:0] a);
        case (a)
            5'd12:   return m_sr;
            5'd13:   return m_cause | m_ip;
            5'd14:   return m_epc;
            5'd15:   return PRID;
`ifdef CP0_TIMER_EN
            5'd9:    return m_count;
            5'd11:   return m_compare;
`endif
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_sr = 0; m_cause = 0; m_ip = 0; m_epc = EPC_RST;
            m_count = 0; m_compare = 0; m_tpend = 0;
        end else begin
            logic iq, ir, tset;
            logic [31:0] nip;
            iq   = m_irq();
            ir   = m_intreq();
            nip  = (32'(hwint) << 10) | (m_tpend ? TOPBIT : 32'd0);
            tset = (m_count == m_compare) && (m_compare != 0);
            m_count = m_count + 1;
            m_tpend = m_tpend | tset;
            if (ir) begin
                m_sr    = m_sr | 32'h2;
                m_cause = {bd_m, 31'd0} | (iq ? 32'd0 : 32'({exc_code, 2'b00})) | (m_cause & 32'h300);
                m_epc   = bd_m ? ((pc_m & ~32'h3) - 32'd4) : (pc_m & ~32'h3);
            end else begin
                if (cp0_we) begin
                    case (cp0_addr)
                        5'd12: m_sr = cp0_wd & SRM;
                        5'd13: m_cause = (m_cause & ~32'h300) | (cp0_wd & 32'h300);
                        5'd14: m_epc = cp0_wd & ~32'h3;
                        5'd9:  m_count = cp0_wd;
                        5'd11: begin m_compare = cp0_wd; m_tpend = 0; end
                        default: ;
                    endcase
                end
                if (eret) m_sr = m_sr & ~32'h2;
            end
`ifndef CP0_TIMER_EN
            m_count = 0; m_compare = 0; m_tpend = 0;
`endif
            m_ip = nip;
        end
        ready = 1;
    end

    always @(negedge clk) begin
        if (ready) begin
            chk("model int_req", 32'(int_req), 32'(m_intreq()));
            chk("model exl", 32'(exl), 32'(m_sr[1]));
            chk("model epc", epc, m_epc);
            chk("model cp0_rd", cp0_rd, m_rd(cp0_addr));
        end
    end

    task automatic idle();
        exc_valid = 0; cp0_we = 0; eret = 0; bd_m = 0;
    endtask

    task automatic nxt();
        @(posedge clk); #1; idle();
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        cp0_we = 1; cp0_addr = a; cp0_wd = d; nxt();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        exc_valid = 1; cp0_addr = 5'd15;
        @(negedge clk);
        chk("int_req in reset", 32'(int_req), 32'd0);
        @(posedge clk); #1;
        idle(); reset = 1;
        @(negedge clk);
        chk("reset prid", cp0_rd, 32'h0000_4C51);
        chk("reset epc", epc, 32'h0000_3000);
        chk("reset int_req", 32'(int_req), 32'd0);
        chk("reset exl", 32'(exl), 32'd0);
        nxt();

        mtc0(5'd12, 32'h0000_0401);
        hwint = 6'b000001; pc_m = 32'h3010;
        @(negedge clk); chk("hwint latency", 32'(int_req), 32'd0);
        nxt();
        @(negedge clk); chk("hwint irq", 32'(int_req), 32'd1);
        nxt(); hwint = '0; cp0_addr = 5'd13;
        @(negedge clk);
        chk("irq exl", 32'(exl), 32'd1);
        chk("irq exccode", cp0_rd & 32'h7C, 32'd0);
        chk("irq epc", epc, 32'h3010);
        eret = 1; nxt();
        mtc0(5'd12, 32'h0000_0400);
        hwint = 6'b000001;
        repeat (3) begin
            @(negedge clk); chk("ie=0 blocks", 32'(int_req), 32'd0);
            nxt();
        end
        hwint = '0; nxt();

        exc_valid = 1; exc_code = 5'd4; bd_m = 1; pc_m = 32'h3024;
        @(negedge clk); chk("exc int_req", 32'(int_req), 32'd1);
        nxt(); cp0_addr = 5'd13;
        @(negedge clk);
        chk("bd epc", epc, 32'h3020);
        chk("bd cause", cp0_rd & 32'h8000_007C, 32'h8000_0010);
        eret = 1; nxt();

        mtc0(5'd12, 32'h0000_0401);
        hwint = 6'b000001; nxt();
        exc_valid = 1; exc_code = 5'd12; pc_m = 32'h3040;
        cp0_we = 1; cp0_addr = 5'd14; cp0_wd = 32'h5000;
        @(negedge clk); chk("int+exc int_req", 32'(int_req), 32'd1);
        nxt(); hwint = '0; cp0_addr = 5'd13;
        @(negedge clk);
        chk("int beats exc", cp0_rd & 32'h7C, 32'd0);
        chk("mtc0 discarded", epc, 32'h3040);
        eret = 1; nxt();

        mtc0(5'd12, 32'h0000_0101);
        mtc0(5'd13, 32'h0000_0100);
        @(negedge clk); chk("sw irq", 32'(int_req), 32'd1);
        nxt();
        @(negedge clk); chk("sw exl", 32'(exl), 32'd1);
        eret = 1; nxt();
        @(negedge clk); chk("eret exl", 32'(exl), 32'd0);
        nxt();
        cp0_we = 1; cp0_addr = 5'd12; cp0_wd = 32'h0000_0402; eret = 1; nxt();
        cp0_addr = 5'd12;
        @(negedge clk);
        chk("eret+mtc0 sr", cp0_rd, 32'h0000_0400);
        chk("eret+mtc0 exl", 32'(exl), 32'd0);
        mtc0(5'd13, 32'h0);
        mtc0(5'd12, 32'h0);

`ifdef CP0_TIMER_EN
        mtc0(5'd9, 32'd0);
        mtc0(5'd11, 32'd10);
        mtc0(5'd12, TOPBIT | 32'h1);
        repeat (9) nxt();
        @(negedge clk); chk("timer early", 32'(int_req), 32'd0);
        nxt();
        @(negedge clk); chk("timer irq", 32'(int_req), 32'd1);
        nxt();
        mtc0(5'd11, 32'd20);
        nxt(); cp0_addr = 5'd13;
        @(negedge clk); chk("timer cleared", cp0_rd & TOPBIT, 32'd0);
        mtc0(5'd11, 32'd0);
        mtc0(5'd12, 32'h0);
`endif

        for (int i = 0; i < 3000; i++) begin
            logic [4:0] tbl [8];
            tbl = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd0, 5'd0};
            tbl[7] = 5'($urandom);
            hwint     = ($urandom % 6 == 0) ? N'($urandom) : '0;
            exc_valid = ($urandom % 10 == 0);
            exc_code  = 5'($urandom);
            pc_m      = $urandom;
            bd_m      = 1'($urandom);
            eret      = ($urandom % 12 == 0);
            cp0_we    = ($urandom % 4 == 0);
            cp0_addr  = tbl[$urandom % 8];
            cp0_wd    = ($urandom % 2 == 0) ? ($urandom % 64) : $urandom;
            @(posedge clk); #1;
        end
        idle();
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
